// File: rtl/serial_subtractor_4bit_pkg.sv
// Shared definitions for the bit-serial subtractor: default width, FSM state
// encoding and the bit-counter sizing helper.
package serial_subtractor_4bit_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // A one-bit counter still needs one bit of storage, hence the floor of 1.
    function automatic int cntWidth(input int w);
        return (w <= 2) ? 1 : $clog2(w);
    endfunction

    localparam int DEFAULT_CNT_W = cntWidth(DEFAULT_WIDTH);

endpackage

// File: rtl/serial_subtractor_4bit_full_subtractor.sv
// Single-bit full subtractor cell: d = a - b - br, with the borrow passed on
// to the next more significant bit.
module full_subtractor
    import serial_subtractor_4bit_pkg::*;
(
    input  logic a_i,
    input  logic b_i,
    input  logic br_i,
    output logic d_o,
    output logic br_o
);

    always_comb begin
        d_o  = a_i ^ b_i ^ br_i;
        br_o = (~a_i & b_i) | (~(a_i ^ b_i) & br_i);
    end

endmodule

// File: rtl/serial_subtractor_4bit.sv
// Bit-serial two's-complement subtractor computing D = A - B - Br one bit per
// clock through a single full-subtractor cell, with a start/busy/done handshake.
module serial_subtractor_4bit
    import serial_subtractor_4bit_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             start_in,
    input  logic [WIDTH-1:0] A_in,
    input  logic [WIDTH-1:0] B_in,
    input  logic             Br_in,
    output logic             busy_out,
    output logic             done_out,
    output logic [WIDTH-1:0] D_out,
    output logic             Br_out,
    output logic             V_out
);

    localparam int CntW = cntWidth(WIDTH);

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  aSr_q, aSr_d;
    logic [WIDTH-1:0]  bSr_q, bSr_d;
    logic              br_q, br_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              aMsb_q, aMsb_d;
    logic              bMsb_q, bMsb_d;
    logic [WIDTH-1:0]  dOut_q, dOut_d;
    logic              brOut_q, brOut_d;
    logic              vOut_q, vOut_d;
    logic              done_q, done_d;

    logic              dBit;
    logic              brBit;
    logic              accept;
    logic              lastBit;

    full_subtractor uCell (
        .a_i  (aSr_q[0]),
        .b_i  (bSr_q[0]),
        .br_i (br_q),
        .d_o  (dBit),
        .br_o (brBit)
    );

    assign accept  = (state_q == IDLE) && start_in;
    assign lastBit = (state_q == RUN) && (cnt_q == CntW'(WIDTH - 1));

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_in) state_d = RUN;
            RUN:     if (lastBit)  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy_out = (state_q == RUN);
        done_out = done_q;
        D_out    = dOut_q;
        Br_out   = brOut_q;
        V_out    = vOut_q;
    end

    // The minuend register doubles as the result register: each difference bit
    // enters at the MSB as the consumed minuend bit leaves at the LSB.
    always_comb begin
        aSr_d   = aSr_q;
        bSr_d   = bSr_q;
        br_d    = br_q;
        cnt_d   = cnt_q;
        aMsb_d  = aMsb_q;
        bMsb_d  = bMsb_q;
        dOut_d  = dOut_q;
        brOut_d = brOut_q;
        vOut_d  = vOut_q;
        done_d  = 1'b0;
        if (accept) begin
            aSr_d  = A_in;
            bSr_d  = B_in;
            br_d   = Br_in;
            cnt_d  = '0;
            aMsb_d = A_in[WIDTH-1];
            bMsb_d = B_in[WIDTH-1];
        end else if (state_q == RUN) begin
            aSr_d = {dBit, aSr_q[WIDTH-1:1]};
            bSr_d = {1'b0, bSr_q[WIDTH-1:1]};
            br_d  = brBit;
            cnt_d = cnt_q + CntW'(1);
            if (lastBit) begin
                dOut_d  = {dBit, aSr_q[WIDTH-1:1]};
                brOut_d = brBit;
                vOut_d  = (aMsb_q != bMsb_q) && (dBit != aMsb_q);
                done_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            aSr_q   <= '0;
            bSr_q   <= '0;
            br_q    <= 1'b0;
            cnt_q   <= '0;
            aMsb_q  <= 1'b0;
            bMsb_q  <= 1'b0;
            dOut_q  <= '0;
            brOut_q <= 1'b0;
            vOut_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            aSr_q   <= aSr_d;
            bSr_q   <= bSr_d;
            br_q    <= br_d;
            cnt_q   <= cnt_d;
            aMsb_q  <= aMsb_d;
            bMsb_q  <= bMsb_d;
            dOut_q  <= dOut_d;
            brOut_q <= brOut_d;
            vOut_q  <= vOut_d;
            done_q  <= done_d;
        end
    end

endmodule

// File: tb/tb_serial_subtractor_4bit.sv
// Directed testbench for serial_subtractor_4bit: hand-computed vectors, handshake
// timing, ignored starts, mid-operation reset and back-to-back throughput.
module tb_serial_subtractor_4bit;

    logic       clk;
    logic       rst;
    logic       start;
    logic [3:0] aIn;
    logic [3:0] bIn;
    logic       brIn;
    logic       busy;
    logic       done;
    logic [3:0] dOut;
    logic       brOut;
    logic       vOut;

    int checkCount = 0;
    int passCount  = 0;

    serial_subtractor_4bit #(.WIDTH(4)) dut (
        .clk_in   (clk),
        .rst_in   (rst),
        .start_in (start),
        .A_in     (aIn),
        .B_in     (bIn),
        .Br_in    (brIn),
        .busy_out (busy),
        .done_out (done),
        .D_out    (dOut),
        .Br_out   (brOut),
        .V_out    (vOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    endtask

    // Presents one operation at a falling edge and returns at the falling edge
    // after the accepting rising edge, with start already dropped.
    task automatic applyStimulus(input logic [3:0] a, input logic [3:0] b, input logic br);
        @(negedge clk);
        aIn   = a;
        bIn   = b;
        brIn  = br;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkOutput("busyAfterAccept", busy, 1);
    endtask

    task automatic waitDone(output int busyCnt, output bit seen);
        busyCnt = 0;
        seen    = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
            else if (busy) busyCnt++;
        end
    endtask

    task automatic runOp(input string tag, input logic [3:0] a, input logic [3:0] b,
                         input logic br, input logic [3:0] expD, input logic expBr,
                         input logic expV);
        logic [3:0] heldD;
        int         busyCnt;
        bit         seen;
        heldD = dOut;
        applyStimulus(a, b, br);
        checkOutput({tag, "_heldD"}, dOut, heldD);
        waitDone(busyCnt, seen);
        checkOutput({tag, "_doneSeen"}, seen, 1);
        checkOutput({tag, "_busyCycles"}, busyCnt, 3);
        checkOutput({tag, "_busyInDone"}, busy, 0);
        checkOutput({tag, "_D"}, dOut, expD);
        checkOutput({tag, "_Br"}, brOut, expBr);
        checkOutput({tag, "_V"}, vOut, expV);
        @(negedge clk);
        checkOutput({tag, "_donePulse"}, done, 0);
        checkOutput({tag, "_Dhold"}, dOut, expD);
    endtask

    initial begin
        int  busyCnt;
        bit  seen;
        int  extraDone;
        int  gap;
        int  busyGlitch;

        rst   = 1'b1;
        start = 1'b0;
        aIn   = '0;
        bIn   = '0;
        brIn  = 1'b0;
        #12;
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_D", dOut, 0);
        checkOutput("rst_Br", brOut, 0);
        checkOutput("rst_V", vOut, 0);
        @(negedge clk);
        rst = 1'b0;

        $display("[TB] basic subtraction vectors");
        runOp("5m3", 4'd5, 4'd3, 1'b0, 4'h2, 1'b0, 1'b0);
        runOp("7m8", 4'd7, 4'd8, 1'b0, 4'hF, 1'b1, 1'b1);
        runOp("8m7", 4'd8, 4'd7, 1'b0, 4'h1, 1'b0, 1'b1);
        runOp("6m6b", 4'd6, 4'd6, 1'b1, 4'hF, 1'b1, 1'b0);

        $display("[TB] start during busy is ignored");
        applyStimulus(4'd5, 4'd3, 1'b0);
        aIn   = 4'd9;
        bIn   = 4'd1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        waitDone(busyCnt, seen);
        checkOutput("ign_doneSeen", seen, 1);
        checkOutput("ign_busyCycles", busyCnt, 2);
        checkOutput("ign_D", dOut, 4'h2);
        checkOutput("ign_Br", brOut, 0);
        extraDone = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done || busy) extraDone++;
        end
        checkOutput("ign_noSecondOp", extraDone, 0);

        $display("[TB] reset in the middle of an operation");
        runOp("7m8b", 4'd7, 4'd8, 1'b0, 4'hF, 1'b1, 1'b1);
        applyStimulus(4'd5, 4'd3, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("midRst_busy", busy, 0);
        checkOutput("midRst_done", done, 0);
        checkOutput("midRst_D", dOut, 0);
        checkOutput("midRst_Br", brOut, 0);
        checkOutput("midRst_V", vOut, 0);
        #2;
        rst = 1'b0;
        extraDone = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done || busy) extraDone++;
        end
        checkOutput("midRst_noDone", extraDone, 0);
        runOp("4m1", 4'd4, 4'd1, 1'b0, 4'h3, 1'b0, 1'b0);

        $display("[TB] back-to-back with start held high");
        @(negedge clk);
        aIn   = 4'd3;
        bIn   = 4'd1;
        brIn  = 1'b0;
        start = 1'b1;
        for (int op = 0; op < 3; op++) begin
            gap        = 0;
            busyGlitch = 0;
            seen       = 1'b0;
            for (int i = 0; i < 12 && !seen; i++) begin
                @(negedge clk);
                gap++;
                if (done) seen = 1'b1;
                else if (!busy) busyGlitch++;
            end
            if (op == 2) start = 1'b0;
            checkOutput("b2b_doneSeen", seen, 1);
            checkOutput("b2b_period", gap, 5);
            checkOutput("b2b_busyGap", busyGlitch, 0);
            checkOutput("b2b_busyInDone", busy, 0);
            checkOutput("b2b_D", dOut, 4'h2);
        end
        @(negedge clk);
        checkOutput("b2b_stopped", busy, 0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/serial_subtractor_4bit.md
Name: serial_subtractor_4bit

Overview:
- Bit-serial two's-complement subtractor: computes D = A - B - Br over WIDTH clock cycles using one full-subtractor cell.
- Inverse-direction companion to the team's combinational ripple Full_Adder.
- Used where area beats latency.
- Start/busy/done handshake; results held in output registers until the next completed operation.

Parameters:
WIDTH, 4, operand and result width in bits (must be >= 2)

Ports:
clk_in  input  1  clock; all state updates on rising edge
rst_in  input  1  asynchronous, active-high reset
start_in  input  1  request; sampled only in IDLE
A_in  input  WIDTH  minuend, captured on accepting edge
B_in  input  WIDTH  subtrahend, captured on accepting edge
Br_in  input  1  borrow-in, captured on accepting edge
busy_out  output  1  high while operation in progress
done_out  output  1  one-cycle pulse when results update
D_out  output  WIDTH  difference, registered
Br_out  output  1  final borrow-out (1 = unsigned A < B + Br_in)
V_out  output  1  signed overflow flag

Behaviour:
- Reset (async, any time):
  - State goes to IDLE.
  - busy_out=0, done_out=0, D_out=0, Br_out=0, V_out=0.
  - Shift registers and bit counter cleared.
  - Any in-progress operation is aborted; no done_out is ever produced for it.
- FSM states: IDLE, RUN.
- IDLE:
  - If start_in=1 at edge E0, load a_sr<=A_in, b_sr<=B_in, br<=Br_in, cnt<=0, latch A_in[WIDTH-1] and B_in[WIDTH-1] for the overflow check, then go to RUN.
  - busy_out is high from E0 onward.
- RUN, each edge:
  - Process the LSB of a_sr/b_sr:
    - d = a^b^br
    - br_next = (~a&b) | (~(a^b)&br)
  - Shift d into the MSB of the result shift register.
  - Shift a_sr/b_sr right; cnt<=cnt+1.
- Completion, on edge E_WIDTH (the cnt==WIDTH-1 edge):
  - Final bit is processed.
  - D_out<=completed result.
  - Br_out<=br_next.
  - V_out <= (A_msb != B_msb) && (D_msb != A_msb).
  - done_out<=1 for exactly one cycle; busy_out<=0; state goes to IDLE.
- Latency: done_out is high in the cycle after edge E0+WIDTH. busy_out is high for exactly WIDTH cycles.
- start_in while busy_out=1 is ignored, with no queuing. Operands changing during RUN have no effect.
- Back-to-back: start_in held high during the done_out cycle is accepted at that cycle's edge. Throughput is one operation per WIDTH+1 cycles.
- D_out, Br_out and V_out hold their previous values throughout RUN and change only on completion edges.
- Wrap-around: results are modulo 2^WIDTH; underflow is signalled only via Br_out and V_out.

Decomposition:
- Shared package holds:
  - WIDTH default.
  - State encoding constants: IDLE=1'b0, RUN=1'b1.
  - Counter width localparam: clog2(WIDTH).
- One natural sub-module: full_subtractor (combinational inputs a, b, br; outputs d, br_out), instantiated once in the datapath.

Test Plan:
- Reset, then start with A=5, B=3, Br_in=0 -> after 4 busy cycles, done_out pulse with D_out=2, Br_out=0, V_out=0.
- A=7, B=8, Br_in=0 -> D_out=4'hF, Br_out=1, V_out=1 (signed 7-(-8) overflows).
- A=8, B=7, Br_in=0 -> D_out=1, Br_out=0, V_out=1. Then A=6, B=6, Br_in=1 -> D_out=4'hF, Br_out=1, V_out=0.
- Start A=5, B=3. Pulse start_in again with A=9, B=1 during busy -> ignored. Single done_out with D_out=2.
- Start A=5, B=3, then assert rst_in after 2 RUN edges -> all outputs immediately 0. No done_out follows. Next start A=4, B=1 -> D_out=3.
- Hold start_in high continuously with A=3, B=1 -> done_out pulses every 5 cycles, D_out=2 each time, busy_out low only during done cycles.
